// File: rtl/ctrlport_arbiter_rr.sv
// ---------------------------------------------------------------------------
// ctrlport_arbiter_rr
//
// Round-robin arbiter that shares one ControlPort master among NUM_MASTERS
// single-cycle-pulse requesters. Each requester has a one-deep request
// buffer. Only one transaction is outstanding on the shared port at a time.
// Each response is routed back to the requester that issued it.
//
// Handshake: a requester issues a one-cycle pulse on wr and/or rd together
// with addr/data/byte_en. It receives exactly one one-cycle ack pulse per
// accepted request, with status/data valid in the ack cycle. A pulse that
// arrives while the requester's buffer is still occupied is discarded, and
// req_dropped reports that. The exception is a pulse in the cycle its
// previous request completes, which is accepted. On the shared side, the
// m_req_* pulse lasts one cycle and m_resp_ack is honoured only from the
// following cycle until the transaction completes.
//
// Optional feature (compile-time macro CTRLPORT_ARB_TIMEOUT_EN):
//   When the macro is defined, a WAIT-state counter forces an error response
//   (status 2'b10, data 0) if no ack arrives within TIMEOUT_CYCLES.
//   When it is undefined, WAIT lasts until an ack arrives.
//
// Ports:
//   ctrlport_clk, ctrlport_rst_n   clock, asynchronous active-low reset
//   s_ctrlport_req_*               per-master request (wr, rd, addr, data, byte_en)
//   s_ctrlport_resp_*              per-master response (ack, status, data)
//   m_ctrlport_req_*               shared request towards the CPLD link
//   m_ctrlport_resp_*              shared response from the CPLD link
//   req_dropped                    per-master pulse: request discarded (buffer full)
// ---------------------------------------------------------------------------
module ctrlport_arbiter_rr #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        ctrlport_clk,
    input  logic                        ctrlport_rst_n,

    input  logic [NUM_MASTERS-1:0]      s_ctrlport_req_wr,
    input  logic [NUM_MASTERS-1:0]      s_ctrlport_req_rd,
    input  logic [20*NUM_MASTERS-1:0]   s_ctrlport_req_addr,
    input  logic [32*NUM_MASTERS-1:0]   s_ctrlport_req_data,
    input  logic [4*NUM_MASTERS-1:0]    s_ctrlport_req_byte_en,
    output logic [NUM_MASTERS-1:0]      s_ctrlport_resp_ack,
    output logic [2*NUM_MASTERS-1:0]    s_ctrlport_resp_status,
    output logic [32*NUM_MASTERS-1:0]   s_ctrlport_resp_data,

    output logic                        m_ctrlport_req_wr,
    output logic                        m_ctrlport_req_rd,
    output logic [19:0]                 m_ctrlport_req_addr,
    output logic [31:0]                 m_ctrlport_req_data,
    output logic [3:0]                  m_ctrlport_req_byte_en,
    input  logic                        m_ctrlport_resp_ack,
    input  logic [1:0]                  m_ctrlport_resp_status,
    input  logic [31:0]                 m_ctrlport_resp_data,

    output logic [NUM_MASTERS-1:0]      req_dropped
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // Elaboration-time guard on parameter ranges.
    generate
        if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
            $error("ctrlport_arbiter_rr: NUM_MASTERS must be 2..8");
        end
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("ctrlport_arbiter_rr: TIMEOUT_CYCLES must be 2..65535");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state;
    logic [PW-1:0]          ptr;        // first master searched on the next grant
    logic [PW-1:0]          owner;      // master whose transaction is in flight
    logic                   req_cycle;  // high during the m_req pulse cycle

    // One-deep request buffers
    logic [NUM_MASTERS-1:0] pending;
    logic [NUM_MASTERS-1:0] buf_wr;
    logic [NUM_MASTERS-1:0] buf_rd;
    logic [19:0]            buf_addr    [NUM_MASTERS];
    logic [31:0]            buf_data    [NUM_MASTERS];
    logic [3:0]             buf_byte_en [NUM_MASTERS];

    logic                   found;
    logic [PW-1:0]          winner;
    logic [PW:0]            cand;
    logic                   ack_take;
    logic                   timeout_hit;
    logic                   complete;
    logic [NUM_MASTERS-1:0] done;

`ifdef CTRLPORT_ARB_TIMEOUT_EN
    logic [15:0]            to_cnt;
`endif

    // -----------------------------------------------------------------------
    // Round-robin search: ptr, ptr+1, ... modulo NUM_MASTERS. The extra bit
    // in cand holds the unwrapped sum before it is folded back into range.
    // -----------------------------------------------------------------------
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_MASTERS)) begin
                cand = cand - (PW+1)'(NUM_MASTERS);
            end
            if (!found && pending[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    // An ack during the request pulse cycle belongs to no transaction of ours.
    assign ack_take = (state == ST_WAIT) && !req_cycle && m_ctrlport_resp_ack;

`ifdef CTRLPORT_ARB_TIMEOUT_EN
    // The counter is 0 in the pulse cycle, so reaching TIMEOUT_CYCLES-1 here
    // places the forced ack exactly TIMEOUT_CYCLES cycles after the pulse.
    // A real ack in the same cycle wins.
    assign timeout_hit = (state == ST_WAIT) && !req_cycle && !m_ctrlport_resp_ack &&
                         (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = ack_take || timeout_hit;

    always_comb begin
        done = '0;
        if (complete) begin
            done[owner] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Request capture. A master's buffer stays occupied from capture until
    // its response completes. A pulse in the completion cycle refills the
    // buffer at once, so pending stays set.
    // -----------------------------------------------------------------------
    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            pending     <= '0;
            req_dropped <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                buf_addr[i]    <= '0;
                buf_data[i]    <= '0;
                buf_byte_en[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                req_dropped[i] <= 1'b0;
                if (s_ctrlport_req_wr[i] || s_ctrlport_req_rd[i]) begin
                    if (!pending[i] || done[i]) begin
                        pending[i]     <= 1'b1;
                        buf_wr[i]      <= s_ctrlport_req_wr[i];
                        buf_rd[i]      <= s_ctrlport_req_rd[i];
                        buf_addr[i]    <= s_ctrlport_req_addr[20*i +: 20];
                        buf_data[i]    <= s_ctrlport_req_data[32*i +: 32];
                        buf_byte_en[i] <= s_ctrlport_req_byte_en[4*i +: 4];
                    end else begin
                        req_dropped[i] <= 1'b1;
                    end
                end else if (done[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM with registered outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge ctrlport_clk or negedge ctrlport_rst_n) begin
        if (!ctrlport_rst_n) begin
            state                  <= ST_IDLE;
            ptr                    <= '0;
            owner                  <= '0;
            req_cycle              <= 1'b0;
            m_ctrlport_req_wr      <= 1'b0;
            m_ctrlport_req_rd      <= 1'b0;
            m_ctrlport_req_addr    <= '0;
            m_ctrlport_req_data    <= '0;
            m_ctrlport_req_byte_en <= '0;
            s_ctrlport_resp_ack    <= '0;
            s_ctrlport_resp_status <= '0;
            s_ctrlport_resp_data   <= '0;
`ifdef CTRLPORT_ARB_TIMEOUT_EN
            to_cnt                 <= '0;
`endif
        end else begin
            m_ctrlport_req_wr   <= 1'b0;
            m_ctrlport_req_rd   <= 1'b0;
            req_cycle           <= 1'b0;
            s_ctrlport_resp_ack <= '0;

            case (state)
                ST_IDLE: begin
                    if (found) begin
                        m_ctrlport_req_wr      <= buf_wr[winner];
                        m_ctrlport_req_rd      <= buf_rd[winner];
                        m_ctrlport_req_addr    <= buf_addr[winner];
                        m_ctrlport_req_data    <= buf_data[winner];
                        m_ctrlport_req_byte_en <= buf_byte_en[winner];
                        owner                  <= winner;
                        ptr                    <= (winner == PW'(NUM_MASTERS - 1)) ?
                                                  '0 : winner + 1'b1;
                        req_cycle              <= 1'b1;
                        state                  <= ST_WAIT;
`ifdef CTRLPORT_ARB_TIMEOUT_EN
                        to_cnt                 <= '0;
`endif
                    end
                end

                ST_WAIT: begin
`ifdef CTRLPORT_ARB_TIMEOUT_EN
                    to_cnt <= to_cnt + 16'd1;
`endif
                    if (complete) begin
                        s_ctrlport_resp_ack[owner] <= 1'b1;
                        if (ack_take) begin
                            s_ctrlport_resp_status[int'(owner)*2 +: 2]  <= m_ctrlport_resp_status;
                            s_ctrlport_resp_data[int'(owner)*32 +: 32]  <= m_ctrlport_resp_data;
                        end else begin
                            // Forced completion: error status, no data.
                            s_ctrlport_resp_status[int'(owner)*2 +: 2]  <= 2'b10;
                            s_ctrlport_resp_data[int'(owner)*32 +: 32]  <= 32'h0;
                        end
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrlport_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_ctrlport_arbiter_rr
//
// Self-checking bench for ctrlport_arbiter_rr. It uses four masters. A
// transaction-level reference model predicts every output in every cycle.
// Directed scenarios and a randomized phase drive the design. Define
// CTRLPORT_ARB_TIMEOUT_EN to enable the timeout scenario and the timeout
// rules in the model.
// ---------------------------------------------------------------------------
module tb_ctrlport_arbiter_rr;

    localparam int N  = 4;
    localparam int TO = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [N-1:0]    s_req_wr      = '0;
    logic [N-1:0]    s_req_rd      = '0;
    logic [20*N-1:0] s_req_addr    = '0;
    logic [32*N-1:0] s_req_data    = '0;
    logic [4*N-1:0]  s_req_byte_en = '0;
    logic [N-1:0]    s_resp_ack;
    logic [2*N-1:0]  s_resp_status;
    logic [32*N-1:0] s_resp_data;
    logic            m_req_wr, m_req_rd;
    logic [19:0]     m_req_addr;
    logic [31:0]     m_req_data;
    logic [3:0]      m_req_byte_en;
    logic            m_resp_ack    = 1'b0;
    logic [1:0]      m_resp_status = '0;
    logic [31:0]     m_resp_data   = '0;
    logic [N-1:0]    req_dropped;

    ctrlport_arbiter_rr #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ctrlport_clk           (clk),
        .ctrlport_rst_n         (rst_n),
        .s_ctrlport_req_wr      (s_req_wr),
        .s_ctrlport_req_rd      (s_req_rd),
        .s_ctrlport_req_addr    (s_req_addr),
        .s_ctrlport_req_data    (s_req_data),
        .s_ctrlport_req_byte_en (s_req_byte_en),
        .s_ctrlport_resp_ack    (s_resp_ack),
        .s_ctrlport_resp_status (s_resp_status),
        .s_ctrlport_resp_data   (s_resp_data),
        .m_ctrlport_req_wr      (m_req_wr),
        .m_ctrlport_req_rd      (m_req_rd),
        .m_ctrlport_req_addr    (m_req_addr),
        .m_ctrlport_req_data    (m_req_data),
        .m_ctrlport_req_byte_en (m_req_byte_en),
        .m_ctrlport_resp_ack    (m_resp_ack),
        .m_ctrlport_resp_status (m_resp_status),
        .m_ctrlport_resp_data   (m_resp_data),
        .req_dropped            (req_dropped)
    );

    // ---------------- stimulus for the current cycle ----------------
    logic [N-1:0] in_wr, in_rd;
    logic         in_ack;
    logic [1:0]   in_ack_st;
    logic [31:0]  in_ack_dat;
    logic [19:0]  f_addr [N];
    logic [31:0]  f_data [N];
    logic [3:0]   f_be   [N];

    // ---------------- reference model state ----------------
    // st: 0 = buffer empty, 1 = waiting for grant, 2 = granted and in flight
    int           st      [N];
    int           since_c [N];
    logic [N-1:0] b_wr, b_rd;
    logic [19:0]  b_addr [N];
    logic [31:0]  b_data [N];
    logic [3:0]   b_be   [N];
    int           mptr, owner, issue_cyc, free_at, cyc;
    bit           busy;

    // Outputs the model expects in the next sampled cycle
    logic            e_wr, e_rd;
    logic [19:0]     e_addr;
    logic [31:0]     e_data;
    logic [3:0]      e_be;
    logic [N-1:0]    e_ack, e_drop;
    logic [2*N-1:0]  e_st;
    logic [32*N-1:0] e_rdat;

    // ---------------- scoreboard / bookkeeping ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_mreq, n_sack, n_drop;
    int           last_mreq_cyc, last_sack_cyc;
    logic [N-1:0] last_sack_vec;
    bit           last_req_seen;
    logic [19:0]  obs_q[$];
    logic [19:0]  exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            st[i] = 0; since_c[i] = 0;
            b_addr[i] = '0; b_data[i] = '0; b_be[i] = '0;
        end
        b_wr = '0; b_rd = '0;
        mptr = 0; owner = 0; issue_cyc = 0; free_at = 0; busy = 1'b0;
        e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_data = '0; e_be = '0;
        e_ack = '0; e_drop = '0; e_st = '0; e_rdat = '0;
    endtask

    // Consumes the inputs applied in cycle cyc and predicts the outputs of cyc+1.
    task automatic model_update();
        bit got;
        int i;
        e_wr = 1'b0; e_rd = 1'b0; e_ack = '0; e_drop = '0;
        got = 1'b0;
        // completion of the in-flight transaction
        if (busy && cyc > issue_cyc) begin
            if (in_ack) begin
                e_st[2*owner +: 2]    = in_ack_st;
                e_rdat[32*owner +: 32] = in_ack_dat;
                got = 1'b1;
            end
`ifdef CTRLPORT_ARB_TIMEOUT_EN
            else if (cyc == issue_cyc + TO - 1) begin
                e_st[2*owner +: 2]    = 2'b10;
                e_rdat[32*owner +: 32] = 32'h0;
                got = 1'b1;
            end
`endif
            if (got) begin
                e_ack[owner] = 1'b1;
                st[owner]    = 0;
                busy         = 1'b0;
                free_at      = cyc + 2;
            end
        end
        // request capture or drop
        for (int m = 0; m < N; m++) begin
            if (in_wr[m] || in_rd[m]) begin
                if (st[m] == 0) begin
                    st[m] = 1; since_c[m] = cyc;
                    b_wr[m] = in_wr[m]; b_rd[m] = in_rd[m];
                    b_addr[m] = f_addr[m]; b_data[m] = f_data[m]; b_be[m] = f_be[m];
                end else begin
                    e_drop[m] = 1'b1;
                end
            end
        end
        // grant for the next cycle
        if (!busy && cyc + 1 >= free_at) begin
            got = 1'b0;
            for (int k = 0; k < N; k++) begin
                i = (mptr + k) % N;
                if (!got && st[i] == 1 && since_c[i] <= cyc - 1) begin
                    got = 1'b1;
                    e_wr = b_wr[i]; e_rd = b_rd[i];
                    e_addr = b_addr[i]; e_data = b_data[i]; e_be = b_be[i];
                    busy = 1'b1; issue_cyc = cyc + 1; owner = i; st[i] = 2;
                    mptr = (i + 1) % N;
                end
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, ".m_req_wr"},    128'(m_req_wr),      128'(e_wr));
        check({pfx, ".m_req_rd"},    128'(m_req_rd),      128'(e_rd));
        check({pfx, ".m_req_addr"},  128'(m_req_addr),    128'(e_addr));
        check({pfx, ".m_req_data"},  128'(m_req_data),    128'(e_data));
        check({pfx, ".m_req_be"},    128'(m_req_byte_en), 128'(e_be));
        check({pfx, ".s_resp_ack"},  128'(s_resp_ack),    128'(e_ack));
        check({pfx, ".s_resp_st"},   128'(s_resp_status), 128'(e_st));
        check({pfx, ".s_resp_data"}, 128'(s_resp_data),   128'(e_rdat));
        check({pfx, ".req_dropped"}, 128'(req_dropped),   128'(e_drop));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        in_wr = '0; in_rd = '0; in_ack = 1'b0; in_ack_st = '0; in_ack_dat = '0;
    endtask

    task automatic drive_pins();
        s_req_wr = in_wr;
        s_req_rd = in_rd;
        for (int i = 0; i < N; i++) begin
            s_req_addr[20*i +: 20]  = f_addr[i];
            s_req_data[32*i +: 32]  = f_data[i];
            s_req_byte_en[4*i +: 4] = f_be[i];
        end
        m_resp_ack    = in_ack;
        m_resp_status = in_ack_st;
        m_resp_data   = in_ack_dat;
    endtask

    // One clock cycle: apply inputs, check outputs on the falling edge, advance the model.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_pins();
        @(negedge clk);
        check_outputs("cyc");
        if (m_req_wr || m_req_rd) begin
            n_mreq++;
            obs_q.push_back(m_req_addr);
            last_mreq_cyc = cyc;
        end
        if (|s_resp_ack) begin
            last_sack_cyc = cyc;
            last_sack_vec = s_resp_ack;
        end
        n_sack += $countones(s_resp_ack);
        n_drop += $countones(req_dropped);
        last_req_seen = m_req_wr || m_req_rd;
        model_update();
    endtask

    task automatic reset_dut(input bit immediate);
        @(posedge clk);
        #2;
        idle_inputs();
        drive_pins();
        rst_n = 1'b0;
        model_reset();
        #1;
        if (immediate) check_outputs("rst_now");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("rst_hold");
        rst_n = 1'b1;
        last_req_seen = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        cyc = 0;
        n_mreq = 0; n_sack = 0; n_drop = 0;
        last_mreq_cyc = 0; last_sack_cyc = 0; last_sack_vec = '0; last_req_seen = 1'b0;
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            f_addr[i] = '0; f_data[i] = '0; f_be[i] = '0;
        end
        model_reset();
        reset_dut(1'b0);

        // Single write from master 2
        f_addr[2] = 20'h00010; f_data[2] = 32'h0000_ABCD; f_be[2] = 4'b0011;
        c0 = cyc + 1;
        for (int j = 0; j < 10; j++) begin
            idle_inputs();
            if (j == 0) in_wr = 4'b0100;
            if (j == 4) in_ack = 1'b1;
            step();
        end
        check("wr_req_latency",  128'(last_mreq_cyc - c0), 128'(2));
        check("wr_resp_latency", 128'(last_sack_cyc - c0), 128'(5));
        check("wr_resp_vec",     128'(last_sack_vec),      128'(4'b0100));

        // Fairness: all four read together, master 0 retries after its ack
        reset_dut(1'b0);
        for (int i = 0; i < N; i++) f_addr[i] = 20'h00100 + 20'(i);
        obs_q.delete();
        exp_q.delete();
        exp_q.push_back(20'h00100); exp_q.push_back(20'h00101);
        exp_q.push_back(20'h00102); exp_q.push_back(20'h00103);
        exp_q.push_back(20'h00200);
        for (int j = 0; j < 20; j++) begin
            idle_inputs();
            if (j == 0) in_rd = 4'hF;
            if (j == 4) begin in_rd = 4'h1; f_addr[0] = 20'h00200; end
            in_ack = last_req_seen;
            in_ack_dat = 32'h0000_1234;
            step();
        end
        check("fair_count", 128'(obs_q.size()), 128'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check("fair_order", 128'(obs_q[k]), 128'(exp_q[k]));

        // Read data routing to master 1
        f_addr[1] = 20'h00300;
        for (int j = 0; j < 8; j++) begin
            idle_inputs();
            if (j == 0) in_rd = 4'b0010;
            in_ack = last_req_seen;
            in_ack_st = 2'b01;
            in_ack_dat = 32'hDEAD_BEEF;
            step();
        end
        check("route_data1",   128'(s_resp_data[63:32]),  128'(32'hDEAD_BEEF));
        check("route_status1", 128'(s_resp_status[3:2]),  128'(2'b01));
        check("route_data0",   128'(s_resp_data[31:0]),   128'(32'h0000_1234));
        check("route_status0", 128'(s_resp_status[1:0]),  128'(2'b00));

        // Overflow on master 3, then a refill in its completion cycle
        f_addr[3] = 20'h00400;
        obs_q.delete();
        n_drop = 0;
        for (int j = 0; j < 12; j++) begin
            idle_inputs();
            if (j == 0 || j == 2) in_wr = 4'b1000;
            if (j == 5) begin in_wr = 4'b1000; f_addr[3] = 20'h00401; end
            in_ack = (j == 5 || j == 8);
            step();
        end
        check("ovf_drops", 128'(n_drop), 128'(1));
        check("ovf_mreqs", 128'(obs_q.size()), 128'(2));
        if (obs_q.size() == 2) begin
            check("ovf_first",  128'(obs_q[0]), 128'(20'h00400));
            check("ovf_refill", 128'(obs_q[1]), 128'(20'h00401));
        end

`ifdef CTRLPORT_ARB_TIMEOUT_EN
        // Timeout with no slave ack, then a late ack
        f_addr[0] = 20'h00500;
        n_sack = 0;
        c0 = cyc + 1;
        for (int j = 0; j < 26; j++) begin
            idle_inputs();
            if (j == 0) in_rd = 4'b0001;
            if (j == 20) in_ack = 1'b1;
            step();
        end
        check("to_req_latency",  128'(last_mreq_cyc - c0),            128'(2));
        check("to_resp_latency", 128'(last_sack_cyc - last_mreq_cyc), 128'(TO));
        check("to_status",       128'(s_resp_status[1:0]),            128'(2'b10));
        check("to_sack_count",   128'(n_sack),                        128'(1));
`endif

        // Reset while a transaction is in WAIT
        f_addr[2] = 20'h00600;
        for (int j = 0; j < 4; j++) begin
            idle_inputs();
            if (j == 0) in_wr = 4'b0100;
            step();
        end
        reset_dut(1'b1);
        n_mreq = 0;
        n_sack = 0;
        for (int j = 0; j < 30; j++) begin
            idle_inputs();
            if (j == 0) in_ack = 1'b1;
            step();
        end
        check("rst_no_mreq", 128'(n_mreq), 128'(0));
        check("rst_no_sack", 128'(n_sack), 128'(0));

        // Randomized traffic
        for (int j = 0; j < 1500; j++) begin
            int r;
            idle_inputs();
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 7);
                in_wr[i] = (r == 0 || r == 2);
                in_rd[i] = (r == 1 || r == 2);
                f_addr[i] = 20'($urandom);
                f_data[i] = $urandom;
                f_be[i]   = 4'($urandom_range(0, 15));
            end
            // Ack droughts between cycles 400 and 460 exercise long waits.
            in_ack     = (j >= 400 && j < 460) ? 1'b0 : ($urandom_range(0, 2) == 0);
            in_ack_st  = 2'($urandom_range(0, 3));
            in_ack_dat = $urandom;
            step();
            if (j == 700) reset_dut(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
